// File: rtl/spi_hk_master.sv
// SPI mode-0 master for the housekeeping SPI slave.
// User side is a byte stream; wire order is MSB first both ways.
module spi_hk_master #(
   parameter int CLK_DIV   = 2,
   parameter int MAX_LEN_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MAX_LEN_W-1:0] len,
   input  logic [7:0]           tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 csb,
   output logic                 sck,
   output logic                 sdi,
   input  logic                 sdo
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [MAX_LEN_W-1:0] LAST_BYTE = MAX_LEN_W'(1);

   typedef enum logic [2:0] {
      IDLE, LOAD, SHIFT_LO, SHIFT_HI, TAIL, GAP
   } state_t;

   state_t               state;
   logic [DW-1:0]        div;
   logic [2:0]           bit_cnt;
   logic [MAX_LEN_W-1:0] byte_cnt;
   logic [6:0]           tx_sh;
   logic [7:0]           rx_sh;
   logic                 phase_end;

   assign phase_end = (div == DIV_LAST);
   assign tx_ready  = (state == LOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         div      <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         csb      <= 1'b1;
         sck      <= 1'b0;
         sdi      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               div <= '0;
               if (start && len != '0) begin
                  byte_cnt <= len;
                  csb      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (tx_valid) begin
                  tx_sh   <= tx_data[6:0];
                  sdi     <= tx_data[7];
                  bit_cnt <= 3'd7;
                  div     <= '0;
                  state   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (phase_end) begin
                  div   <= '0;
                  sck   <= 1'b1;
                  rx_sh <= {rx_sh[6:0], sdo};
                  state <= SHIFT_HI;
               end else begin
                  div <= div + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (phase_end) begin
                  div <= '0;
                  sck <= 1'b0;
                  if (bit_cnt != 3'd0) begin
                     bit_cnt <= bit_cnt - 1'b1;
                     sdi     <= tx_sh[6];
                     tx_sh   <= {tx_sh[5:0], 1'b0};
                     state   <= SHIFT_LO;
                  end else begin
                     // rx_sh already holds all 8 bits sampled on rising edges
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                     byte_cnt <= byte_cnt - 1'b1;
                     state    <= (byte_cnt == LAST_BYTE) ? TAIL : LOAD;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end
            TAIL: begin
               if (phase_end) begin
                  div   <= '0;
                  csb   <= 1'b1;
                  state <= GAP;
               end else begin
                  div <= div + 1'b1;
               end
            end
            GAP: begin
               if (phase_end) begin
                  div   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sdi   <= 1'b0;
                  state <= IDLE;
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_hk_master.sv
// Bench for spi_hk_master: table vectors, random transactions
// against a transaction-level model, and hand-written corner sequences.
module tb_spi_hk_master;

   localparam int D = 2;

   typedef struct packed {
      logic [2:0]      len;
      logic [3:0][7:0] tx;
      logic [3:0][7:0] resp;
      logic [3:0][7:0] stall;
      logic            lpbk;
      logic            poke;
      logic [3:0][7:0] exp_rx;
      logic [15:0]     exp_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       start = 1'b0;
   logic [4:0] len = '0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy, done, csb, sck, sdi, sdo;

   logic       start_b = 1'b0;
   logic [4:0] len_b = '0;
   logic [7:0] tx_data_b = '0;
   logic       tx_valid_b = 1'b0;
   logic       tx_ready_b;
   logic [7:0] rx_data_b;
   logic       rx_valid_b, busy_b, done_b, csb_b, sck_b, sdi_b, sdo_b;

   always #5 clk = ~clk;

   spi_hk_master #(.CLK_DIV(D), .MAX_LEN_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .csb(csb), .sck(sck), .sdi(sdi), .sdo(sdo)
   );

   spi_hk_master #(.CLK_DIV(1), .MAX_LEN_W(5)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .len(len_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
      .done(done_b), .csb(csb_b), .sck(sck_b), .sdi(sdi_b), .sdo(sdo_b)
   );

   int n_chk = 0;
   int n_fail = 0;

   // slave model: presents resp bytes MSB first, advancing on sck fall
   logic       lpbk = 1'b1;
   logic [7:0] resp [0:3];
   int         bitpos = 0;
   logic [4:0] bp;
   logic       slv_bit;

   always_comb begin
      bp = 5'(bitpos);
      slv_bit = 1'b0;
      if (bitpos < 32) slv_bit = resp[bp[4:3]][~bp[2:0]];
   end

   assign sdo   = lpbk ? sdi : slv_bit;
   assign sdo_b = sdi_b;

   logic [7:0] rx_q[$];
   logic [7:0] mosi_q[$];
   logic [7:0] mosi_sh = '0;
   int mosi_bits = 0;
   int done_cnt = 0, busy_cyc = 0, sck_rises = 0, csb_rises = 0, viol = 0;
   logic sck_prev = 1'b0, csb_prev = 1'b1;

   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (csb && sck != sck_prev) viol++;
      if (csb && !csb_prev) csb_rises++;
      if (!csb && sck && !sck_prev) begin
         sck_rises++;
         mosi_sh = {mosi_sh[6:0], sdi};
         mosi_bits++;
         if (mosi_bits == 8) begin
            mosi_q.push_back(mosi_sh);
            mosi_bits = 0;
         end
      end
      if (csb) begin
         mosi_bits = 0;
         bitpos = 0;
      end else if (!sck && sck_prev) begin
         bitpos++;
      end
      sck_prev = sck;
      csb_prev = csb;
   end

   logic [7:0] rxb_q[$];
   int doneb_cnt = 0, csb_run = 0, csb_last = 0, idle_run = 0, idle_last = 0;

   always @(negedge clk) begin
      if (rx_valid_b) rxb_q.push_back(rx_data_b);
      if (done_b) doneb_cnt++;
      if (csb_b) csb_run++;
      else begin
         if (csb_run != 0) csb_last = csb_run;
         csb_run = 0;
      end
      if (!busy_b) idle_run++;
      else begin
         if (idle_run != 0) idle_last = idle_run;
         idle_run = 0;
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input string nm);
      int rx0, mo0, d0, b0, s0, c0, v0, k, bad, tmo, n;
      n = int'(v.len);
      rx0 = rx_q.size(); mo0 = mosi_q.size(); d0 = done_cnt;
      b0 = busy_cyc; s0 = sck_rises; c0 = csb_rises; v0 = viol;
      bad = 0; tmo = 0;
      lpbk = v.lpbk;
      for (int i = 0; i < 4; i++) resp[i] = v.resp[i];
      start = 1'b1; len = 5'(v.len);
      tick();
      start = 1'b0; len = '0;
      for (int i = 0; i < n; i++) begin
         k = 0;
         while (!tx_ready && k < 200) begin tick(); k++; end
         if (k >= 200) tmo++;
         for (int s = 0; s < int'(v.stall[i]); s++) begin
            if (!(tx_ready && !sck && !csb)) bad++;
            tick();
         end
         tx_data = v.tx[i]; tx_valid = 1'b1;
         tick();
         tx_valid = 1'b0;
         if (v.poke && i == 0) begin
            start = 1'b1; len = 5'd3;
            tick();
            start = 1'b0; len = '0;
         end
      end
      k = 0;
      while (!done && k < 400) begin tick(); k++; end
      if (k >= 400) tmo++;
      tick(); tick();
      check({nm, "_timeout"}, tmo, 0);
      check({nm, "_stall"}, bad, 0);
      check({nm, "_busy_cyc"}, busy_cyc - b0, 32'(v.exp_busy));
      check({nm, "_done_cnt"}, done_cnt - d0, 1);
      check({nm, "_rx_cnt"}, rx_q.size() - rx0, n);
      check({nm, "_mosi_cnt"}, mosi_q.size() - mo0, n);
      check({nm, "_sck_rises"}, sck_rises - s0, 8 * n);
      check({nm, "_csb_rises"}, csb_rises - c0, 1);
      check({nm, "_sck_viol"}, viol - v0, 0);
      check({nm, "_end_state"}, {busy, csb}, 2'b01);
      for (int i = 0; i < n; i++) begin
         if (rx0 + i < rx_q.size())
            check($sformatf("%s_rx%0d", nm, i), rx_q[rx0 + i], v.exp_rx[i]);
         if (mo0 + i < mosi_q.size())
            check($sformatf("%s_mosi%0d", nm, i), mosi_q[mo0 + i], v.tx[i]);
      end
   endtask

   vec_t tbl [6];

   initial begin
      vec_t v;
      int k, e, bad, s0, r0, d0, bc1, bc2, tmo;

      tbl[0] = '{len:3'd1, tx:32'h000000A5, resp:32'h0, stall:32'h0,
                 lpbk:1'b1, poke:1'b0, exp_rx:32'h000000A5, exp_busy:16'd37};
      tbl[1] = '{len:3'd3, tx:32'h00000480, resp:32'h00110000, stall:32'h0,
                 lpbk:1'b0, poke:1'b0, exp_rx:32'h00110000, exp_busy:16'd103};
      tbl[2] = '{len:3'd2, tx:32'h0000C33C, resp:32'h0000965A,
                 stall:32'h00000A00, lpbk:1'b0, poke:1'b0,
                 exp_rx:32'h0000965A, exp_busy:16'd80};
      tbl[3] = '{len:3'd4, tx:32'h7E8100FF, resp:32'h0, stall:32'h0,
                 lpbk:1'b1, poke:1'b0, exp_rx:32'h7E8100FF, exp_busy:16'd136};
      tbl[4] = '{len:3'd1, tx:32'h00000042, resp:32'h00000099, stall:32'h0,
                 lpbk:1'b0, poke:1'b1, exp_rx:32'h00000099, exp_busy:16'd37};
      tbl[5] = '{len:3'd2, tx:32'h00008001, resp:32'h00003CC3,
                 stall:32'h00000003, lpbk:1'b0, poke:1'b0,
                 exp_rx:32'h00003CC3, exp_busy:16'd73};
      for (int i = 0; i < 4; i++) resp[i] = '0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick();
      check("rst_csb", csb, 1'b1);
      check("rst_sck", sck, 1'b0);
      check("rst_sdi", sdi, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);

      for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // start with len=0 must do nothing
      d0 = done_cnt; bad = 0;
      start = 1'b1; len = '0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (busy || !csb || sck || tx_ready) bad++;
         tick();
      end
      check("len0_idle", bad, 0);
      check("len0_done", done_cnt - d0, 0);

      // reset in the middle of byte 1
      lpbk = 1'b0; resp[0] = 8'h0F;
      s0 = sck_rises; r0 = rx_q.size(); d0 = done_cnt; tmo = 0;
      start = 1'b1; len = 5'd1;
      tick();
      start = 1'b0; len = '0;
      tx_data = 8'hF0; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      k = 0;
      while (sck_rises - s0 < 4 && k < 200) begin tick(); k++; end
      if (k >= 200) tmo++;
      check("midrst_timeout", tmo, 0);
      reset = 1'b1;
      tick();
      check("midrst_csb", csb, 1'b1);
      check("midrst_sck", sck, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_pulses", {rx_valid, done}, 2'b00);
      reset = 1'b0;
      repeat (40) tick();
      check("midrst_no_rx", rx_q.size() - r0, 0);
      check("midrst_no_done", done_cnt - d0, 0);
      run_txn(tbl[0], "post_rst");

      for (int r = 0; r < 10; r++) begin
         v = '0;
         v.len = 3'($urandom_range(4, 1));
         v.lpbk = 1'($urandom_range(1, 0));
         e = int'(v.len) * (1 + 16 * D) + 2 * D;
         for (int i = 0; i < int'(v.len); i++) begin
            v.tx[i] = 8'($urandom);
            v.resp[i] = 8'($urandom);
            v.stall[i] = 8'($urandom_range(3, 0));
            v.exp_rx[i] = v.lpbk ? v.tx[i] : v.resp[i];
            e += int'(v.stall[i]);
         end
         v.exp_busy = 16'(e);
         run_txn(v, $sformatf("rnd%0d", r));
      end

      // CLK_DIV=1: restart in the done cycle
      r0 = rxb_q.size(); d0 = doneb_cnt; tmo = 0;
      tx_data_b = 8'h3C; tx_valid_b = 1'b1;
      start_b = 1'b1; len_b = 5'd1;
      tick();
      start_b = 1'b0;
      k = 0; bc1 = 0;
      while (!done_b && k < 100) begin
         if (busy_b) bc1++;
         tick(); k++;
      end
      if (k >= 100) tmo++;
      start_b = 1'b1; len_b = 5'd1; tx_data_b = 8'hC5;
      tick();
      start_b = 1'b0;
      check("b2b_restart", {busy_b, csb_b}, 2'b10);
      k = 0; bc2 = 0;
      while (!done_b && k < 100) begin
         if (busy_b) bc2++;
         tick(); k++;
      end
      if (k >= 100) tmo++;
      tx_valid_b = 1'b0;
      tick(); tick();
      check("b2b_timeout", tmo, 0);
      check("b2b_busy1", bc1, 19);
      check("b2b_busy2", bc2, 19);
      check("b2b_idle_gap", idle_last, 1);
      check("b2b_csb_high", csb_last, 2);
      check("b2b_done_cnt", doneb_cnt - d0, 2);
      check("b2b_rx_cnt", rxb_q.size() - r0, 2);
      if (rxb_q.size() - r0 == 2) begin
         check("b2b_rx0", rxb_q[r0], 8'h3C);
         check("b2b_rx1", rxb_q[r0 + 1], 8'hC5);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1);
   end

endmodule
